spi_flash_read_arbiter: RTL
===========================

// Module: spi_flash_read_arbiter
// PURPOSE
//  Shares the SPI flash read path between two requesters (e.g. ROM loader, disk image fetch).
//  Round-robin grants a request, then issues READ (0x03) + 24-bit address + N dummy-TX bytes.
//  Drives them through the byte-level SPI shift engine and owns flash chip_select.
//  Returns each received byte with requester ID; sits between the C64 core fetch logic and spi_block.
// PARAMETERS
//  CMD_READ  8'h03  flash read opcode sent as first byte
//  CS_GAP    4      cycles chip_select held high in GAP state between transactions (>=1)
// PORTS
//  clk          in   1   system clock (clk_wiz output domain)
//  reset        in   1   synchronous, active-high reset
//  req0_valid   in   1   requester 0 read request; hold until req0_ready
//  req0_addr    in   24  requester 0 start byte address
//  req0_len     in   8   requester 0 byte count; 0 means 256
//  req0_ready   out  1   one-cycle accept pulse; addr/len latched this cycle
//  req1_valid/req1_addr/req1_len/req1_ready   same as requester 0
//  rd_data      out  8   received byte
//  rd_valid     out  1   rd_data valid; held until rd_ready
//  rd_ready     in   1   consumer accepts byte when rd_valid & rd_ready
//  rd_id        out  1   requester owning rd_data
//  rd_last      out  1   rd_data is final byte of burst
//  sh_start     out  1   one-cycle pulse: shift engine sends sh_tx
//  sh_tx        out  8   byte to transmit, valid with sh_start
//  sh_done      in   1   one-cycle pulse: byte exchange complete
//  sh_rx        in   8   received byte, valid with sh_done
//  chip_select  out  1   flash CS, active low, registered
//  busy         out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset: state IDLE, chip_select=1, sh_start=0, sh_tx=0, rd_valid=0, rd_last=0, rd_id=0,
//   reqN_ready=0, busy=0, last_grant=1 (req0 wins first tie). Reset mid-op aborts at once;
//   sh_done arriving in IDLE/GAP ignored.
//  States: IDLE -> SETUP -> CMD -> A2 -> A1 -> A0 -> DATA <-> HOLD -> GAP -> IDLE.
//  IDLE: if rd_valid=0 and any reqN_valid: grant; both valid -> grant != last_grant.
//   Pulse reqN_ready, latch addr/len/id, update last_grant, go SETUP.
//  SETUP: chip_select=0 this cycle. Next cycle sh_start with sh_tx=CMD_READ, enter CMD.
//  CMD/A2/A1/A0: wait sh_done. On it, next cycle pulse sh_start with next byte:
//   addr[23:16], addr[15:8], addr[7:0], then 8'h00 entering DATA.
//   Max one sh_start outstanding.
//  DATA: on sh_done: rd_data=sh_rx, rd_valid=1, rd_id, rd_last=(remaining==1); go HOLD.
//  HOLD: on rd_valid & rd_ready: rd_valid=0.
//   Not last: sh_start(0x00) next cycle, back to DATA.
//   Last byte: chip_select=1 registered on final sh_done cycle+1 (not delayed by rd_ready);
//   HOLD exits to GAP when handshake done.
//  Byte counter: 9-bit, loaded {len==0,len}; decremented per sh_done in DATA; len 0 = 256.
//  GAP: chip_select=1, count CS_GAP cycles, then IDLE. Min CS-high between bursts = CS_GAP+1.
//  rd_data/rd_id/rd_last stable while rd_valid & !rd_ready.
//  Address not incremented by block; flash auto-increments; crossing 0xFFFFFF wraps in flash.
// TESTING
//  1 req0 addr=0x123456 len=1 -> sh_tx 03,12,34,56,00; CS low across all; one rd_valid id=0 last=1.
//  2 req0+req1 valid same cycle after reset -> req0 served, then req1; repeat -> req0 (alternates).
//  3 rd_ready low 5 cycles mid-burst -> rd_data stable, no sh_start, CS low; resumes after ready.
//  4 req1 len=0 -> 256 rd_valid beats, rd_last only on 256th, id=1.
//  5 reset in A1 -> next cycle CS=1, busy=0, rd_valid=0; later sh_done ignored; held req re-granted.
//  6 back-to-back requests, CS_GAP=4 -> CS high exactly 5 cycles between bursts.

Source files
------------

// File: rtl/spi_flash_read_arbiter.sv
// Round-robin arbiter sharing the SPI flash read path between two requesters.
// Issues READ + 24-bit address + dummy bytes through a byte shift engine and returns tagged data.
module spi_flash_read_arbiter #(
  parameter logic [7:0] CMD_READ = 8'h03,
  parameter int         CS_GAP   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  input  logic [7:0]  req0_len,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  input  logic [7:0]  req1_len,
  output logic        req1_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_id,
  output logic        rd_last,
  output logic        sh_start,
  output logic [7:0]  sh_tx,
  input  logic        sh_done,
  input  logic [7:0]  sh_rx,
  output logic        chip_select,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_CMD, S_A2, S_A1, S_A0, S_DATA, S_HOLD, S_GAP
  } state_t;

  localparam logic [7:0] GAP_LOAD = 8'(CS_GAP);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [23:0] addr_q, addr_d;
  logic [8:0]  remaining_q, remaining_d;
  logic [7:0]  gap_q, gap_d;
  logic        cs_q, cs_d;
  logic        sh_start_q, sh_start_d;
  logic [7:0]  sh_tx_q, sh_tx_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_id_q, rd_id_d;
  logic        rd_last_q, rd_last_d;
  logic        ready0_q, ready0_d;
  logic        ready1_q, ready1_d;

  logic        grant_id;
  logic [7:0]  grant_len;

  assign grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign grant_len = grant_id ? req1_len : req0_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= 24'h0;
      remaining_q  <= 9'd0;
      gap_q        <= 8'd0;
      cs_q         <= 1'b1;
      sh_start_q   <= 1'b0;
      sh_tx_q      <= 8'h00;
      rd_data_q    <= 8'h00;
      rd_valid_q   <= 1'b0;
      rd_id_q      <= 1'b0;
      rd_last_q    <= 1'b0;
      ready0_q     <= 1'b0;
      ready1_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      gap_q        <= gap_d;
      cs_q         <= cs_d;
      sh_start_q   <= sh_start_d;
      sh_tx_q      <= sh_tx_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_id_q      <= rd_id_d;
      rd_last_q    <= rd_last_d;
      ready0_q     <= ready0_d;
      ready1_q     <= ready1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    gap_d        = gap_q;
    cs_d         = cs_q;
    sh_start_d   = 1'b0;
    sh_tx_d      = sh_tx_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_valid_q;
    rd_id_d      = rd_id_q;
    rd_last_d    = rd_last_q;
    ready0_d     = 1'b0;
    ready1_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rd_valid_q && (req0_valid || req1_valid)) begin
          ready0_d     = ~grant_id;
          ready1_d     = grant_id;
          owner_d      = grant_id;
          last_grant_d = grant_id;
          addr_d       = grant_id ? req1_addr : req0_addr;
          remaining_d  = {grant_len == 8'd0, grant_len};
          cs_d         = 1'b0;
          state_d      = S_SETUP;
        end
      end
      S_SETUP: begin
        sh_start_d = 1'b1;
        sh_tx_d    = CMD_READ;
        state_d    = S_CMD;
      end
      S_CMD: begin
        if (sh_done) begin
          sh_start_d = 1'b1;
          sh_tx_d    = addr_q[23:16];
          state_d    = S_A2;
        end
      end
      S_A2: begin
        if (sh_done) begin
          sh_start_d = 1'b1;
          sh_tx_d    = addr_q[15:8];
          state_d    = S_A1;
        end
      end
      S_A1: begin
        if (sh_done) begin
          sh_start_d = 1'b1;
          sh_tx_d    = addr_q[7:0];
          state_d    = S_A0;
        end
      end
      S_A0: begin
        if (sh_done) begin
          sh_start_d = 1'b1;
          sh_tx_d    = 8'h00;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (sh_done) begin
          rd_data_d   = sh_rx;
          rd_valid_d  = 1'b1;
          rd_id_d     = owner_q;
          rd_last_d   = (remaining_q == 9'd1);
          remaining_d = remaining_q - 9'd1;
          state_d     = S_HOLD;
          // Release the flash as soon as the final byte is in, independent of the consumer.
          if (remaining_q == 9'd1) begin
            cs_d  = 1'b1;
            gap_d = GAP_LOAD;
          end
        end
      end
      S_HOLD: begin
        if (rd_last_q && gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end
        if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
          if (rd_last_q) begin
            state_d = S_GAP;
          end else begin
            sh_start_d = 1'b1;
            sh_tx_d    = 8'h00;
            state_d    = S_DATA;
          end
        end
      end
      S_GAP: begin
        // The HOLD cycle after the last byte already counts toward the CS-high gap.
        if (gap_q <= 8'd1) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  assign req0_ready  = ready0_q;
  assign req1_ready  = ready1_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_id       = rd_id_q;
  assign rd_last     = rd_last_q;
  assign sh_start    = sh_start_q;
  assign sh_tx       = sh_tx_q;
  assign chip_select = cs_q;

endmodule
